// File: rtl/qos_arb_tree.sv
// qos_arb_tree: pipelined max-QoS arbiter, one register level per tree level.
// Ports: clk, rst_n (sync, active-high), s_valid/s_qos requests in,
//        grant_valid/grant_ready handshake, grant_idx/qos/onehot, busy.
module qos_arb_tree #(
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [STREAM_COUNT-1:0]                s_valid,
    input  logic [STREAM_COUNT*T_QOS__WIDTH-1:0]   s_qos,
    input  logic                                   grant_ready,
    output logic                                   grant_valid,
    output logic [$clog2(STREAM_COUNT):0]          grant_idx,
    output logic [T_QOS__WIDTH-1:0]                grant_qos,
    output logic [STREAM_COUNT-1:0]                grant_onehot,
    output logic                                   busy
);
    localparam int W      = T_QOS__WIDTH;
    localparam int N      = STREAM_COUNT;
    localparam int L      = $clog2(N);
    localparam int IW     = L + 1;
    localparam int LEAVES = 2 ** L;
    localparam int NODES  = 2 * LEAVES;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    localparam logic [IW-1:0] NONE = IW'(N);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [W-1:0]  gqos_q, gqos_d;

    // Heap-ordered tree: node 1 is the root (held in gidx/gqos),
    // nodes 2..LEAVES-1 are internal, LEAVES..NODES-1 are the snapshot.
    logic          nv_q [2:NODES-1];
    logic          nv_d [2:NODES-1];
    logic [W-1:0]  nq_q [2:NODES-1];
    logic [W-1:0]  nq_d [2:NODES-1];
    logic [IW-1:0] ni_q [2:NODES-1];
    logic [IW-1:0] ni_d [2:NODES-1];
    logic [IW-1:0] nr_q [2:NODES-1];
    logic [IW-1:0] nr_d [2:NODES-1];

    logic [LEAVES-1:0]   pv;
    logic [LEAVES*W-1:0] pq;
    logic                snap;
    logic                node_sel;
    logic                root_sel;
    logic [IW-1:0]       root_idx;
    logic [W-1:0]        root_qos;
    logic [IW-1:0]       sidx;

    // Padded leaves (N not a power of two) see valid=0.
    assign pv   = LEAVES'(s_valid);
    assign pq   = (LEAVES*W)'(s_qos);
    assign snap = (state_q == IDLE) && (|s_valid);

    function automatic logic a_wins(
        input logic av, input logic [W-1:0] aq, input logic [IW-1:0] ar,
        input logic bv, input logic [W-1:0] bq, input logic [IW-1:0] br
    );
        if (!av) return 1'b0;
        if (!bv) return 1'b1;
        if (aq != bq) return aq > bq;
        return ar < br;
    endfunction

    always_comb begin
        node_sel = 1'b0;
        sidx     = '0;
        for (int i = LEAVES; i < NODES; i++) begin
            nv_d[i] = nv_q[i];
            nq_d[i] = nq_q[i];
            ni_d[i] = ni_q[i];
            nr_d[i] = nr_q[i];
            if (snap) begin
                sidx    = IW'(i - LEAVES);
                nv_d[i] = pv[i-LEAVES];
                nq_d[i] = pv[i-LEAVES] ? pq[(i-LEAVES)*W +: W] : '0;
                ni_d[i] = pv[i-LEAVES] ? sidx : NONE;
                // Distance from rr_ptr, wrapped modulo N.
                nr_d[i] = (sidx >= rr_ptr_q) ? sidx - rr_ptr_q
                                             : sidx - rr_ptr_q + NONE;
            end
        end
        for (int i = 2; i < LEAVES; i++) begin
            node_sel = a_wins(nv_q[2*i], nq_q[2*i], nr_q[2*i],
                              nv_q[2*i+1], nq_q[2*i+1], nr_q[2*i+1]);
            nv_d[i] = nv_q[2*i] | nv_q[2*i+1];
            ni_d[i] = NONE;
            nq_d[i] = '0;
            nr_d[i] = '0;
            if (nv_d[i]) begin
                ni_d[i] = node_sel ? ni_q[2*i] : ni_q[2*i+1];
                nq_d[i] = node_sel ? nq_q[2*i] : nq_q[2*i+1];
                nr_d[i] = node_sel ? nr_q[2*i] : nr_q[2*i+1];
            end
        end
    end

    always_comb begin
        root_sel = a_wins(nv_q[2], nq_q[2], nr_q[2],
                          nv_q[3], nq_q[3], nr_q[3]);
        root_idx = NONE;
        root_qos = '0;
        if (nv_q[2] | nv_q[3]) begin
            root_idx = root_sel ? ni_q[2] : ni_q[3];
            root_qos = root_sel ? nq_q[2] : nq_q[3];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        gqos_d   = gqos_q;
        unique case (state_q)
            IDLE: begin
                if (|s_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                // Root inputs are settled in the last CALC cycle.
                if (cnt_q == IW'(L - 1)) begin
                    state_d = GRANT;
                    gidx_d  = root_idx;
                    gqos_d  = root_qos;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            gidx_q   <= NONE;
            gqos_q   <= '0;
            for (int i = 2; i < NODES; i++) begin
                nv_q[i] <= 1'b0;
                nq_q[i] <= '0;
                ni_q[i] <= NONE;
                nr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            gqos_q   <= gqos_d;
            for (int i = 2; i < NODES; i++) begin
                nv_q[i] <= nv_d[i];
                nq_q[i] <= nq_d[i];
                ni_q[i] <= ni_d[i];
                nr_q[i] <= nr_d[i];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx_q == IW'(i)) grant_onehot[i] = 1'b1;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = gidx_q;
    assign grant_qos   = gqos_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/qos_arb_tree.md
Name: qos_arb_tree

Overview:
Parametrised, pipelined max-QoS arbiter for STREAM_COUNT streams. It is the successor of the 2-input combinational comparator node. It snapshots the valid requests, resolves the winner through a registered comparison tree (one register level per tree level) and presents a grant under a valid/ready handshake. Ties between equal QoS values are broken by a round-robin pointer that advances on every accepted grant. It sits between the per-stream QoS extractors and the stream mux.

Parameters:
T_QOS__WIDTH, 4, width of one QoS value
STREAM_COUNT, 4, number of streams (>=2; need not be a power of two)
Derived L = $clog2(STREAM_COUNT), the number of tree levels and registered stages
Derived IW = $clog2(STREAM_COUNT)+1, the index width; the value STREAM_COUNT means "no stream"

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, ACTIVE-HIGH (the design resets while rst_n==1)
s_valid  in  STREAM_COUNT  per-stream request
s_qos  in  STREAM_COUNT*T_QOS__WIDTH  per-stream QoS; stream i occupies bits [i*W +: W]
grant_ready  in  1  downstream accepts the grant
grant_valid  out  1  grant is presented
grant_idx  out  IW  winning stream index
grant_qos  out  T_QOS__WIDTH  QoS of the winner
grant_onehot  out  STREAM_COUNT  one-hot of grant_idx
busy  out  1  high in CALC or GRANT

Behaviour:
- Reset (rst_n==1 at a clk edge): state IDLE, rr_ptr=0, grant_valid=0, grant_idx=STREAM_COUNT, grant_qos=0, grant_onehot=0, busy=0, all pipeline stages invalid. A reset mid-CALC or mid-GRANT aborts the round; no grant is issued and rr_ptr returns to 0.
- FSM states:
  - IDLE -> CALC when |s_valid. s_valid and s_qos are captured into the level-0 snapshot at that edge.
  - CALC holds for L cycles while the tree levels register, then goes to GRANT.
  - GRANT -> IDLE on grant_valid && grant_ready.
- Inputs are ignored outside IDLE. Requests that change during CALC or GRANT do not affect the current round.
- Latency: if s_valid is non-zero in IDLE during cycle t, grant_valid is high from cycle t+L+1. For N=4 that is t+3; for N=2 it is t+2.
- Tree node function:
  - Each entry carries {valid, qos, idx, rank}, where rank = (idx - rr_ptr) mod STREAM_COUNT, computed at snapshot time.
  - A valid entry beats an invalid one.
  - Among two valid entries, the higher qos wins. If qos is equal, the smaller rank wins.
  - Two invalid entries give an invalid result with idx=STREAM_COUNT and qos=0.
  - Leaves above STREAM_COUNT-1, present when N is not a power of two, are tied invalid.
- Result: the valid stream with the maximum QoS, with ties going to the first index at or after rr_ptr, circularly. QoS 0 is a legal, valid value.
- Handshake:
  - While grant_valid && !grant_ready, grant_idx, grant_qos and grant_onehot are held stable.
  - On accept in cycle g: grant_valid=0 at g+1, rr_ptr <= (grant_idx+1) mod STREAM_COUNT, and state returns to IDLE.
  - The next snapshot can occur at the end of cycle g+1, so maximum throughput is one grant per L+2 cycles.
- After accept, grant_idx and grant_qos keep their last values. grant_valid alone qualifies them.
- Width rule: the rank subtraction is performed in IW bits and wrapped modulo STREAM_COUNT. For a non-power-of-two N, this means "add STREAM_COUNT if negative".

Test Plan:
- Reset: hold rst_n=1 for 2 cycles with s_valid=4'b1111 -> grant_valid=0, grant_idx=4, grant_qos=0, grant_onehot=0, busy=0 throughout.
- Single request (N=4, W=4): s_valid=4'b0100 with qos[2]=5 in cycle t, grant_ready=1 -> grant_valid in cycle t+3 with idx=2, qos=5, onehot=4'b0100; next winner's rr_ptr=3.
- Round-robin ties: qos={3,9,9,1} for streams 0..3, all valid, rr_ptr=0, ready=1, requests held -> successive grants go to idx 1, 2, 1, 2, all with qos=9.
- Backpressure: grant_ready=0 for 5 cycles after grant_valid, and s_qos/s_valid changed meanwhile -> outputs stable and busy=1. On accept, a new snapshot uses the new inputs.
- All zero QoS: all valid, qos all 0, rr_ptr=3 -> idx=3, qos=0, then the next round gives idx=0.
- Reset mid-CALC with N=3: rst_n=1 one cycle after the snapshot -> no grant_valid and rr_ptr=0. Then s_valid=3'b101 with qos 4 and 4 -> idx=0 at t+3 (L=2).
